rx_fcs_check: RTL and testbench

//  Sits directly downstream of the OFDM decoder's byte output (byte_out/byte_out_strobe).

---
 rtl/rx_fcs_check.sv | 130 +++++++++++++
 tb/tb_rx_fcs_check.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fcs_check.sv
// rx_fcs_check: counts PSDU bytes from the OFDM decoder against the SIG length,
// runs reflected CRC-32 over every byte (FCS included), forwards in-length bytes
// and reports the FCS verdict once the last byte has been accepted.
module rx_fcs_check #(
    parameter int LEN_W   = 16,
    parameter int MIN_LEN = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             start,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic [7:0]       byte_in,
    input  logic             byte_in_strobe,
    output logic [7:0]       byte_out,
    output logic             byte_out_strobe,
    output logic [LEN_W-1:0] byte_count,
    output logic             busy,
    output logic             fcs_done,
    output logic             fcs_ok
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       byte_out_q, byte_out_d;
    logic             byte_out_strobe_q, byte_out_strobe_d;
    logic             fcs_done_q, fcs_done_d;
    logic             fcs_ok_q, fcs_ok_d;
    logic [31:0]      crc_upd;

    // One byte of reflected CRC-32, bits consumed LSB first (first bit over the air).
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // CRC value the register would take if the current input byte were accepted.
    always_comb begin
        crc_upd = crc32_byte(crc_q, byte_in);
    end

    // Next-state logic: start always wins, strobes only count while receiving,
    // and a low enable freezes everything while killing the pulse outputs.
    always_comb begin
        state_d           = state_q;
        crc_d             = crc_q;
        count_d           = count_q;
        len_d             = len_q;
        byte_out_d        = byte_out_q;
        byte_out_strobe_d = 1'b0;
        fcs_done_d        = 1'b0;
        fcs_ok_d          = fcs_ok_q;

        if (enable) begin
            if (start) begin
                len_d    = pkt_len;
                count_d  = '0;
                crc_d    = CRC_INIT;
                fcs_ok_d = 1'b0;
                if (pkt_len >= LEN_W'(MIN_LEN)) begin
                    state_d = RECV;
                end else begin
                    state_d    = DONE;
                    fcs_done_d = 1'b1;
                end
            end else if (state_q == RECV && byte_in_strobe) begin
                crc_d             = crc_upd;
                count_d           = count_q + 1'b1;
                byte_out_d        = byte_in;
                byte_out_strobe_d = 1'b1;
                if (count_q + 1'b1 == len_q) begin
                    state_d    = DONE;
                    fcs_done_d = 1'b1;
                    fcs_ok_d   = (crc_upd == CRC_RESIDUE);
                end
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            crc_q             <= CRC_INIT;
            count_q           <= '0;
            len_q             <= '0;
            byte_out_q        <= '0;
            byte_out_strobe_q <= 1'b0;
            fcs_done_q        <= 1'b0;
            fcs_ok_q          <= 1'b0;
        end else begin
            state_q           <= state_d;
            crc_q             <= crc_d;
            count_q           <= count_d;
            len_q             <= len_d;
            byte_out_q        <= byte_out_d;
            byte_out_strobe_q <= byte_out_strobe_d;
            fcs_done_q        <= fcs_done_d;
            fcs_ok_q          <= fcs_ok_d;
        end
    end

    assign byte_out        = byte_out_q;
    assign byte_out_strobe = byte_out_strobe_q;
    assign byte_count      = count_q;
    assign busy            = (state_q == RECV);
    assign fcs_done        = fcs_done_q;
    assign fcs_ok          = fcs_ok_q;

endmodule

// File: tb/tb_rx_fcs_check.sv
// tb_rx_fcs_check: scoreboard bench for rx_fcs_check. Expected bytes and
// completion events are queued as stimulus is driven and popped by a monitor.
module tb_rx_fcs_check;

    localparam int LEN_W = 16;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             start;
    logic [LEN_W-1:0] pkt_len;
    logic [7:0]       byte_in;
    logic             byte_in_strobe;
    logic [7:0]       byte_out;
    logic             byte_out_strobe;
    logic [LEN_W-1:0] byte_count;
    logic             busy;
    logic             fcs_done;
    logic             fcs_ok;

    typedef struct {
        logic             ok;
        logic             with_strobe;
        logic [LEN_W-1:0] count;
        logic             check_count;
    } done_t;

    logic [7:0] exp_bytes[$];
    done_t      exp_done[$];
    int         checks = 0;
    int         errors = 0;
    logic       busy_seen = 1'b0;

    // "123456789" followed by its little-endian FCS
    logic [7:0] t1_stream [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                   8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

    rx_fcs_check #(.LEN_W(LEN_W), .MIN_LEN(5)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .enable          (enable),
        .start           (start),
        .pkt_len         (pkt_len),
        .byte_in         (byte_in),
        .byte_in_strobe  (byte_in_strobe),
        .byte_out        (byte_out),
        .byte_out_strobe (byte_out_strobe),
        .byte_count      (byte_count),
        .busy            (busy),
        .fcs_done        (fcs_done),
        .fcs_ok          (fcs_ok)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic st, input logic [LEN_W-1:0] len,
                                 input logic [7:0] b, input logic stb);
        @(negedge clock);
        enable         = en;
        start          = st;
        pkt_len        = len;
        byte_in        = b;
        byte_in_strobe = stb;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 16'd2, 8'h00, 1'b0);
    endtask

    // Full 13-byte packet; optional corruption of one byte and optional freeze window.
    task automatic sendPacket(input int bad_idx, input logic [7:0] bad_val,
                              input logic exp_ok, input int freeze_at);
        done_t d;
        logic [7:0] b;
        applyStimulus(1'b1, 1'b1, 16'd13, 8'h00, 1'b0);
        d.ok = exp_ok; d.with_strobe = 1'b1; d.count = 16'd13; d.check_count = 1'b1;
        exp_done.push_back(d);
        for (int i = 0; i < 13; i++) begin
            if (i == freeze_at) begin
                for (int k = 0; k < 4; k++)
                    applyStimulus(1'b0, k == 1, 16'd13, 8'hA5 + 8'(k), 1'b1);
            end
            b = (i == bad_idx) ? bad_val : t1_stream[i];
            exp_bytes.push_back(b);
            applyStimulus(1'b1, 1'b0, 16'd2, b, 1'b1);
        end
        idle(1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && (exp_bytes.size() != 0 || exp_done.size() != 0); i++)
            @(negedge clock);
        checkOutput({tag, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
        checkOutput({tag, "_done_left"}, 32'(exp_done.size()), 32'd0);
        exp_bytes.delete();
        exp_done.delete();
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits a byte or a completion.
    always @(posedge clock) begin
        done_t d;
        logic [7:0] eb;
        #1;
        if (busy) busy_seen = 1'b1;
        if (byte_out_strobe) begin
            if (exp_bytes.size() == 0) begin
                checkOutput("byte_expected", 32'(exp_bytes.size()), 32'd1);
            end else begin
                eb = exp_bytes.pop_front();
                checkOutput("byte_out", 32'(byte_out), 32'(eb));
            end
        end
        if (fcs_done) begin
            if (exp_done.size() == 0) begin
                checkOutput("done_expected", 32'(exp_done.size()), 32'd1);
            end else begin
                d = exp_done.pop_front();
                checkOutput("fcs_ok", 32'(fcs_ok), 32'(d.ok));
                checkOutput("done_with_strobe", 32'(byte_out_strobe), 32'(d.with_strobe));
                if (d.check_count) checkOutput("done_count", 32'(byte_count), 32'(d.count));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] global time limit expired");
    end

    initial begin
        done_t d;
        reset_n = 1'b0; enable = 1'b1; start = 1'b0; pkt_len = '0;
        byte_in = '0; byte_in_strobe = 1'b0;
        #22;
        checkOutput("rst_outputs",
                    {byte_out, byte_out_strobe, byte_count, busy, fcs_done, fcs_ok}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);

        // T1 good packet
        sendPacket(-1, 8'h00, 1'b1, -1);
        drain("t1");
        checkOutput("t1_count", 32'(byte_count), 32'd13);
        checkOutput("t1_busy", 32'(busy), 32'd0);

        // T2 corrupted third byte
        sendPacket(2, 8'h32, 1'b0, -1);
        drain("t2");

        // T3 good packet then extra strobes that must be dropped
        sendPacket(-1, 8'h00, 1'b1, -1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'd2, 8'h5A, 1'b1);
        idle(2);
        drain("t3");
        checkOutput("t3_count", 32'(byte_count), 32'd13);
        checkOutput("t3_ok_hold", 32'(fcs_ok), 32'd1);

        // T4 aborted packet, restart with a same-cycle strobe that must be dropped
        applyStimulus(1'b1, 1'b1, 16'd13, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            exp_bytes.push_back(8'h70 + 8'(i));
            applyStimulus(1'b1, 1'b0, 16'd13, 8'h70 + 8'(i), 1'b1);
        end
        checkOutput("t4_busy_mid", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b1, 16'd13, 8'hEE, 1'b1);
        d.ok = 1'b1; d.with_strobe = 1'b1; d.count = 16'd13; d.check_count = 1'b1;
        exp_done.push_back(d);
        for (int i = 0; i < 13; i++) begin
            exp_bytes.push_back(t1_stream[i]);
            applyStimulus(1'b1, 1'b0, 16'd13, t1_stream[i], 1'b1);
        end
        idle(1);
        drain("t4");
        checkOutput("t4_count", 32'(byte_count), 32'd13);

        // T5 short length goes straight to DONE
        busy_seen = 1'b0;
        applyStimulus(1'b1, 1'b1, 16'd3, 8'h00, 1'b0);
        d.ok = 1'b0; d.with_strobe = 1'b0; d.count = 16'd0; d.check_count = 1'b0;
        exp_done.push_back(d);
        @(posedge clock);
        #2;
        checkOutput("t5_done_latency", 32'(fcs_done), 32'd1);
        idle(3);
        drain("t5");
        checkOutput("t5_busy_seen", 32'(busy_seen), 32'd0);

        // T6 freeze window mid-stream with strobes and a start that are ignored
        sendPacket(-1, 8'h00, 1'b1, 6);
        drain("t6");
        checkOutput("t6_count", 32'(byte_count), 32'd13);

        // Reset mid-packet
        applyStimulus(1'b1, 1'b1, 16'd13, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_bytes.push_back(t1_stream[i]);
            applyStimulus(1'b1, 1'b0, 16'd13, t1_stream[i], 1'b1);
        end
        @(negedge clock);
        byte_in_strobe = 1'b0;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_outputs",
                    {byte_out, byte_out_strobe, byte_count, busy, fcs_done, fcs_ok}, 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(10);
        drain("rst_mid");
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
